// File: rtl/id_step_reg.sv
// id_step_reg: IF/ID instruction register and multicycle step sequencer.
// Define ID_STEP_CNT_EN to build the continuation-step counter on STEP_CNT.
module id_step_reg #(
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] F_INST,
  input  logic        F_VALID,
  output logic        F_ACCEPT,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        STEP_LAST,
  input  logic [3:0]  NXT_RM_ADDR,
  input  logic [3:0]  NXT_RSRD_ADDR,
  input  logic [15:0] NXT_PAT,
  input  logic        NXT_PAT_EN,
  input  logic        NXT_LDMSTM_REQ,
  output logic [31:0] INST,
  output logic        VALID,
  output logic        INST_START,
  output logic [3:0]  NEW_RM_ADDR,
  output logic [3:0]  NEW_RSRD_ADDR,
  output logic [15:0] NEW_PAT,
  output logic        NEW_LDMSTM_REQ,
  output logic [4:0]  STEP_CNT
);

  typedef enum logic {
    S_MULTI = 1'b0,
    S_START = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [3:0]  rm_q, rm_d;
  logic [3:0]  rsrd_q, rsrd_d;
  logic [15:0] pat_q, pat_d;
  logic        req_q, req_d;
  logic        load;

  // An empty slot or a finished instruction takes the next fetch.
  assign load     = STEP_LAST | ~valid_q;
  assign F_ACCEPT = ~FLUSH & ~STALL & load;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_START;
    else       state_q <= state_d;
  end

  // Next state: any flush or load restarts at the first step.
  always_comb begin
    state_d = state_q;
    if (FLUSH)       state_d = S_START;
    else if (!STALL) state_d = load ? S_START : S_MULTI;
  end

  // Outputs: first-step flag decoded straight from the state flop.
  always_comb begin
    INST_START = (state_q == S_START);
  end

  // Next values for the instruction and feedback registers.
  always_comb begin
    inst_d  = inst_q;
    valid_d = valid_q;
    rm_d    = rm_q;
    rsrd_d  = rsrd_q;
    pat_d   = pat_q;
    req_d   = req_q;
    if (FLUSH) begin
      inst_d  = RESET_INST;
      valid_d = 1'b0;
      rm_d    = '0;
      rsrd_d  = '0;
      pat_d   = '0;
      req_d   = 1'b0;
    end else if (STALL) begin
      inst_d  = inst_q;
    end else if (load) begin
      inst_d  = F_INST;
      valid_d = F_VALID;
      rm_d    = '0;
      rsrd_d  = '0;
      pat_d   = '0;
      req_d   = 1'b0;
    end else begin
      rm_d    = NXT_RM_ADDR;
      rsrd_d  = NXT_RSRD_ADDR;
      req_d   = NXT_LDMSTM_REQ;
      if (NXT_PAT_EN) pat_d = NXT_PAT;
    end
  end

  // Instruction and feedback registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      inst_q  <= RESET_INST;
      valid_q <= 1'b0;
      rm_q    <= '0;
      rsrd_q  <= '0;
      pat_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      valid_q <= valid_d;
      rm_q    <= rm_d;
      rsrd_q  <= rsrd_d;
      pat_q   <= pat_d;
      req_q   <= req_d;
    end
  end

  assign INST           = inst_q;
  assign VALID          = valid_q;
  assign NEW_RM_ADDR    = rm_q;
  assign NEW_RSRD_ADDR  = rsrd_q;
  assign NEW_PAT        = pat_q;
  assign NEW_LDMSTM_REQ = req_q;

`ifdef ID_STEP_CNT_EN
  logic [4:0] cnt_q, cnt_d;

  // Count continuation steps, saturating at 31.
  always_comb begin
    cnt_d = cnt_q;
    if (FLUSH)
      cnt_d = '0;
    else if (!STALL)
      cnt_d = load ? 5'd0 :
              (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
  end

  // Step counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign STEP_CNT = cnt_q;
`else
  assign STEP_CNT = 5'd0;
`endif

endmodule

// File: tb/tb_id_step_reg.sv
// tb_id_step_reg: scoreboard bench for id_step_reg.
// Reference model tracks steps-taken per instruction as a plain integer.
module tb_id_step_reg;

  localparam logic [31:0] RST_I = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] F_INST = '0;
  logic        F_VALID = 1'b0;
  logic        F_ACCEPT;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        STEP_LAST = 1'b0;
  logic [3:0]  NXT_RM_ADDR = '0;
  logic [3:0]  NXT_RSRD_ADDR = '0;
  logic [15:0] NXT_PAT = '0;
  logic        NXT_PAT_EN = 1'b0;
  logic        NXT_LDMSTM_REQ = 1'b0;
  logic [31:0] INST;
  logic        VALID;
  logic        INST_START;
  logic [3:0]  NEW_RM_ADDR;
  logic [3:0]  NEW_RSRD_ADDR;
  logic [15:0] NEW_PAT;
  logic        NEW_LDMSTM_REQ;
  logic [4:0]  STEP_CNT;

  id_step_reg #(.RESET_INST(RST_I)) dut (
    .CLK(CLK), .nRST(nRST),
    .F_INST(F_INST), .F_VALID(F_VALID),
    .F_ACCEPT(F_ACCEPT),
    .STALL(STALL), .FLUSH(FLUSH),
    .STEP_LAST(STEP_LAST),
    .NXT_RM_ADDR(NXT_RM_ADDR),
    .NXT_RSRD_ADDR(NXT_RSRD_ADDR),
    .NXT_PAT(NXT_PAT),
    .NXT_PAT_EN(NXT_PAT_EN),
    .NXT_LDMSTM_REQ(NXT_LDMSTM_REQ),
    .INST(INST), .VALID(VALID),
    .INST_START(INST_START),
    .NEW_RM_ADDR(NEW_RM_ADDR),
    .NEW_RSRD_ADDR(NEW_RSRD_ADDR),
    .NEW_PAT(NEW_PAT),
    .NEW_LDMSTM_REQ(NEW_LDMSTM_REQ),
    .STEP_CNT(STEP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic        start;
    logic [3:0]  rm;
    logic [3:0]  rsrd;
    logic [15:0] pat;
    logic        req;
    logic [4:0]  cnt;
  } obs_t;

  obs_t reg_q[$];
  logic acc_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_inst;
  logic        m_valid;
  int          m_n;
  logic [3:0]  m_rm, m_rsrd;
  logic [15:0] m_pat;
  logic        m_req;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_inst  = RST_I;
    m_valid = 1'b0;
    m_n     = 0;
    m_rm    = '0;
    m_rsrd  = '0;
    m_pat   = '0;
    m_req   = 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.inst  = m_inst;
    o.valid = m_valid;
    o.start = (m_n == 0);
    o.rm    = m_rm;
    o.rsrd  = m_rsrd;
    o.pat   = m_pat;
    o.req   = m_req;
`ifdef ID_STEP_CNT_EN
    o.cnt   = (m_n > 31) ? 5'd31 : 5'(m_n);
`else
    o.cnt   = 5'd0;
`endif
    return o;
  endfunction

  task automatic drive(input logic rn, input logic [31:0] fi,
                       input logic fv, input logic st,
                       input logic fl, input logic sl,
                       input logic [3:0] rm, input logic [3:0] rs,
                       input logic [15:0] pt, input logic pe,
                       input logic rq);
    @(negedge CLK);
    nRST = rn; F_INST = fi; F_VALID = fv;
    STALL = st; FLUSH = fl; STEP_LAST = sl;
    NXT_RM_ADDR = rm; NXT_RSRD_ADDR = rs;
    NXT_PAT = pt; NXT_PAT_EN = pe;
    NXT_LDMSTM_REQ = rq;
    if (!rn) begin
      model_clear();
      acc_q.push_back(~fl & ~st);
    end else begin
      acc_q.push_back(~fl & ~st & (sl | ~m_valid));
      if (fl) begin
        model_clear();
      end else if (st) begin
        m_n = m_n;
      end else if (sl || !m_valid) begin
        m_inst = fi; m_valid = fv; m_n = 0;
        m_rm = '0; m_rsrd = '0; m_pat = '0; m_req = 1'b0;
      end else begin
        m_n++;
        m_rm = rm; m_rsrd = rs; m_req = rq;
        if (pe) m_pat = pt;
      end
    end
    reg_q.push_back(model_obs());
  endtask

  // Short forms for directed sequences
  task automatic ld(input logic [31:0] fi);
    drive(1, fi, 1, 0, 0, 1, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic stp(input logic sl, input logic [15:0] pt);
    drive(1, 32'hE1A00000, 1, 0, 0, sl, 4'h3, 4'h5, pt, 1, 1);
  endtask

  // Registered-output monitor
  initial begin
    obs_t e;
    forever begin
      @(posedge CLK); #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        chk("INST", INST, e.inst);
        chk("VALID", 32'(VALID), 32'(e.valid));
        chk("INST_START", 32'(INST_START), 32'(e.start));
        chk("NEW_RM", 32'(NEW_RM_ADDR), 32'(e.rm));
        chk("NEW_RSRD", 32'(NEW_RSRD_ADDR), 32'(e.rsrd));
        chk("NEW_PAT", 32'(NEW_PAT), 32'(e.pat));
        chk("NEW_REQ", 32'(NEW_LDMSTM_REQ), 32'(e.req));
        chk("STEP_CNT", 32'(STEP_CNT), 32'(e.cnt));
      end
    end
  end

  // Combinational accept monitor
  initial begin
    logic e;
    forever begin
      @(negedge CLK); #2;
      if (acc_q.size() > 0) begin
        e = acc_q.pop_front();
        chk("F_ACCEPT", 32'(F_ACCEPT), 32'(e));
      end
    end
  end

  initial begin
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single-cycle stream
    ld(32'hE0810002);
    ld(32'hE0432001);
    // LDM rlist 0x0007
    ld(32'hE8900007);
    stp(0, 16'h0006);
    stp(0, 16'h0004);
    stp(1, 16'h0000);
    ld(32'hE8900007);
    // stall two cycles in the multicycle phase
    stp(0, 16'h0006);
    drive(1, 32'h0, 1, 1, 0, 0, 4'h9, 4'h9, 16'hFFFF, 1, 0);
    drive(1, 32'h0, 1, 1, 0, 1, 4'h9, 4'h9, 16'hFFFF, 1, 0);
    stp(0, 16'h0004);
    stp(1, 16'h0000);
    // flush in step 2
    ld(32'hE8900007);
    stp(0, 16'h0006);
    drive(1, 32'h0, 1, 0, 1, 0, 4'h1, 4'h1, 16'h0004, 1, 1);
    ld(32'hE8BD000F);
    // flush with stall, flush with step-last
    stp(0, 16'h000E);
    drive(1, 32'hDEADBEEF, 1, 1, 1, 1, 4'h2, 4'h2, 16'h1, 1, 1);
    ld(32'hE0000091);
    drive(1, 32'hCAFEF00D, 1, 0, 1, 1, 4'h2, 4'h2, 16'h1, 1, 1);
    // bubble load, then ignored feedback while invalid
    drive(1, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 32'hE0810003, 1, 0, 0, 0, 4'hF, 4'hF, 16'hAAAA, 1, 1);
    // mid-sequence reset
    stp(0, 16'h00F0);
    stp(0, 16'h00E0);
    drive(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    ld(32'hE0810004);
    // long sequence to reach counter saturation
    for (int i = 0; i < 40; i++)
      drive(1, 32'h0, 1, 0, 0, 0, 4'(i), 4'(i + 1),
            16'(i * 3), i[0], i[1]);
    stp(1, 16'h0);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 199) != 0), $urandom,
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) == 0),
            4'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
    repeat (3) @(posedge CLK);
    #3;
    chk("drain", 32'(reg_q.size() + acc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
